// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a line-based memory bus.
// Grant in IDLE, one CMD cycle, then a write burst + response wait or a read burst with gaps.
module mem_bus_arbiter #(
    parameter int ADDR_SIZE = 15,
    parameter int BUS_SIZE  = 16,
    parameter int BEATS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req0_command,
    input  logic [1:0]           req1_command,
    input  logic [ADDR_SIZE-1:0] req0_address,
    input  logic [ADDR_SIZE-1:0] req1_address,
    input  logic [BUS_SIZE-1:0]  req0_wdata,
    input  logic [BUS_SIZE-1:0]  req1_wdata,
    output logic                 req0_wnext,
    output logic                 req1_wnext,
    output logic                 req0_rvalid,
    output logic                 req1_rvalid,
    output logic [BUS_SIZE-1:0]  rdata,
    output logic                 req0_done,
    output logic                 req1_done,
    output logic [1:0]           mem_command,
    output logic [ADDR_SIZE-1:0] mem_address,
    output logic [BUS_SIZE-1:0]  mem_wdata,
    output logic                 mem_wvalid,
    input  logic [BUS_SIZE-1:0]  mem_rdata,
    input  logic                 mem_rvalid,
    input  logic                 mem_response
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {IDLE, CMD, WBURST, WRESP, RBURST} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;

    logic pend0, pend1, wbeat, rbeat, done;

    assign pend0 = (req0_command == CMD_READ) || (req0_command == CMD_WRITE);
    assign pend1 = (req1_command == CMD_READ) || (req1_command == CMD_WRITE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (pend0 || pend1) begin
                // On a tie the requester that did not win last time goes first
                gnt_d   = (pend0 && pend1) ? ~last_q : pend1;
                last_d  = gnt_d;
                cmd_d   = gnt_d ? req1_command : req0_command;
                addr_d  = gnt_d ? req1_address : req0_address;
                cnt_d   = '0;
                state_d = CMD;
            end
            CMD: begin
                if (cmd_q == CMD_WRITE) begin
                    state_d = (LAST_BEAT == '0) ? WRESP : WBURST;
                    cnt_d   = (LAST_BEAT == '0) ? '0 : CW'(1);
                end else begin
                    state_d = RBURST;
                    cnt_d   = '0;
                end
            end
            WBURST: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = WRESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRESP: if (mem_response) state_d = IDLE;
            RBURST: if (mem_rvalid) begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
        end
    end

    // Read data and write data are passed straight through so beats keep their cycle
    assign wbeat = ((state_q == CMD) && (cmd_q == CMD_WRITE)) || (state_q == WBURST);
    assign rbeat = (state_q == RBURST) && mem_rvalid;
    assign done  = ((state_q == WRESP) && mem_response) || (rbeat && (cnt_q == LAST_BEAT));

    always_comb begin
        mem_command = (state_q == CMD) ? cmd_q : 2'd0;
        mem_address = (state_q == CMD) ? addr_q : '0;
        mem_wvalid  = wbeat;
        mem_wdata   = wbeat ? (gnt_q ? req1_wdata : req0_wdata) : '0;
        rdata       = rbeat ? mem_rdata : '0;
        req0_wnext  = wbeat && !gnt_q;
        req1_wnext  = wbeat &&  gnt_q;
        req0_rvalid = rbeat && !gnt_q;
        req1_rvalid = rbeat &&  gnt_q;
        req0_done   = done  && !gnt_q;
        req1_done   = done  &&  gnt_q;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed and randomized transactions against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int A = 15;
    localparam int B = 16;
    localparam int BEATS = 8;

    typedef struct packed {
        logic         wnext0, wnext1, rvalid0, rvalid1;
        logic [B-1:0] rdata;
        logic         done0, done1;
        logic [1:0]   mcmd;
        logic [A-1:0] maddr;
        logic [B-1:0] mwdata;
        logic         mwvalid;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] req0_command, req1_command;
    logic [A-1:0] req0_address, req1_address;
    logic [B-1:0] req0_wdata, req1_wdata;
    logic req0_wnext, req1_wnext, req0_rvalid, req1_rvalid, req0_done, req1_done;
    logic [B-1:0] rdata, mem_wdata, mem_rdata;
    logic [1:0] mem_command;
    logic [A-1:0] mem_address;
    logic mem_wvalid, mem_rvalid, mem_response;

    int nvec = 0;
    int nerr = 0;
    int last_m = 1;
    int winners[$];

    mem_bus_arbiter #(.ADDR_SIZE(A), .BUS_SIZE(B), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .req0_command(req0_command), .req1_command(req1_command),
        .req0_address(req0_address), .req1_address(req1_address),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_wnext(req0_wnext), .req1_wnext(req1_wnext),
        .req0_rvalid(req0_rvalid), .req1_rvalid(req1_rvalid),
        .rdata(rdata), .req0_done(req0_done), .req1_done(req1_done),
        .mem_command(mem_command), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_response(mem_response)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t s;
        s.wnext0 = req0_wnext;   s.wnext1 = req1_wnext;
        s.rvalid0 = req0_rvalid; s.rvalid1 = req1_rvalid;
        s.rdata = rdata;
        s.done0 = req0_done;     s.done1 = req1_done;
        s.mcmd = mem_command;    s.maddr = mem_address;
        s.mwdata = mem_wdata;    s.mwvalid = mem_wvalid;
        return s;
    endfunction

    task automatic noise();
        mem_rvalid = 1'($urandom);
        mem_response = 1'($urandom);
        mem_rdata = B'($urandom);
    endtask

    // One arbitration round starting in IDLE with the currently driven commands.
    // base<0: random beat data; rdly<0: random response delay; abort_beat>0: reset at that write beat.
    task automatic run_txn(input bit gappy, input int base, input int rdly, input int abort_beat);
        bit p0, p1, rv;
        int w, dly, n, cyc;
        logic [1:0] cmd;
        logic [A-1:0] addr;
        logic [B-1:0] d [BEATS];
        out_t o, e;
        p0 = (req0_command == 2'd2) || (req0_command == 2'd3);
        p1 = (req1_command == 2'd2) || (req1_command == 2'd3);
        for (int i = 0; i < BEATS; i++) d[i] = (base >= 0) ? B'(base + i) : B'($urandom);
        noise();
        @(negedge clk);
        o = sample(); e = '0; nvec++;
        if (o !== e) begin nerr++; $display("FAIL idle t=%0t got %h want %h", $time, o, e); end
        if (!p0 && !p1) begin
            @(posedge clk); #1;
            return;
        end
        w = (p0 && p1) ? 1 - last_m : (p0 ? 0 : 1);
        last_m = w;
        winners.push_back(w);
        cmd = w ? req1_command : req0_command;
        addr = w ? req1_address : req0_address;
        @(posedge clk); #1;
        // CMD cycle: address inputs wander, latched address must not
        req0_address = A'($urandom); req1_address = A'($urandom);
        req0_wdata = B'($urandom); req1_wdata = B'($urandom);
        if (w == 1) req1_wdata = d[0]; else req0_wdata = d[0];
        noise();
        @(negedge clk);
        o = sample(); e = '0; e.mcmd = cmd; e.maddr = addr;
        if (cmd == 2'd3) begin
            e.mwvalid = 1'b1; e.mwdata = d[0];
            if (w == 1) e.wnext1 = 1'b1; else e.wnext0 = 1'b1;
        end else o.mwdata = '0;
        nvec++;
        if (o !== e) begin nerr++; $display("FAIL cmd t=%0t got %h want %h", $time, o, e); end
        @(posedge clk); #1;
        if (cmd == 2'd3) begin
            for (int b = 1; b < BEATS; b++) begin
                req0_wdata = B'($urandom); req1_wdata = B'($urandom);
                if (w == 1) req1_wdata = d[b]; else req0_wdata = d[b];
                noise();
                if (b == abort_beat) reset = 1'b0;
                @(negedge clk);
                o = sample(); e = '0; e.mwvalid = 1'b1; e.mwdata = d[b];
                if (w == 1) e.wnext1 = 1'b1; else e.wnext0 = 1'b1;
                nvec++;
                if (o !== e) begin nerr++; $display("FAIL wbeat%0d t=%0t got %h want %h", b, $time, o, e); end
                @(posedge clk); #1;
                if (b == abort_beat) begin
                    reset = 1'b1; req0_command = 2'd0; req1_command = 2'd0;
                    last_m = 1;
                    noise();
                    @(negedge clk);
                    o = sample(); e = '0; nvec++;
                    if (o !== e) begin nerr++; $display("FAIL abort t=%0t got %h want %h", $time, o, e); end
                    @(posedge clk); #1;
                    return;
                end
            end
            dly = (rdly >= 0) ? rdly : $urandom_range(0, 6);
            for (int k = 0; k <= dly; k++) begin
                mem_rvalid = 1'($urandom); mem_rdata = B'($urandom);
                mem_response = (k == dly);
                @(negedge clk);
                o = sample(); o.mwdata = '0; e = '0;
                if (k == dly) begin
                    if (w == 1) e.done1 = 1'b1; else e.done0 = 1'b1;
                end
                nvec++;
                if (o !== e) begin nerr++; $display("FAIL wresp%0d t=%0t got %h want %h", k, $time, o, e); end
                @(posedge clk); #1;
            end
        end else begin
            n = 0; cyc = 0;
            while (n < BEATS && cyc < 200) begin
                rv = gappy ? 1'($urandom) : 1'b1;
                mem_rvalid = rv; mem_rdata = B'($urandom); mem_response = 1'($urandom);
                @(negedge clk);
                o = sample(); o.mwdata = '0; e = '0;
                if (rv) begin
                    e.rdata = mem_rdata;
                    if (w == 1) e.rvalid1 = 1'b1; else e.rvalid0 = 1'b1;
                    if (n == BEATS - 1) begin
                        if (w == 1) e.done1 = 1'b1; else e.done0 = 1'b1;
                    end
                end
                nvec++;
                if (o !== e) begin nerr++; $display("FAIL rbeat%0d t=%0t got %h want %h", n, $time, o, e); end
                if (rv) n++;
                cyc++;
                @(posedge clk); #1;
            end
            if (n < BEATS) begin
                nerr++; $display("FAIL rburst_budget got %0d beats want %0d", n, BEATS);
            end
        end
        mem_response = 1'b0; mem_rvalid = 1'b0;
        if (w == 1) req1_command = 2'd0; else req0_command = 2'd0;
    endtask

    task automatic test_reset();
        out_t o;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0_command = 2'($urandom); req1_command = 2'($urandom);
            req0_address = A'($urandom); req1_address = A'($urandom);
            noise();
            @(posedge clk); #1;
            @(negedge clk);
            o = sample(); nvec++;
            if (o !== '0) begin nerr++; $display("FAIL reset t=%0t got %h want 0", $time, o); end
        end
        req0_command = 2'd0; req1_command = 2'd0;
        mem_rvalid = 1'b0; mem_response = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_m = 1;
    endtask

    task automatic test_read_fixed();
        req0_command = 2'd2; req0_address = A'('h0012); req1_command = 2'd0;
        run_txn(1'b0, 'h1000, 0, -1);
    endtask

    task automatic test_write_fixed();
        req1_command = 2'd3; req1_address = A'('h7FFF); req0_command = 2'd0;
        run_txn(1'b0, 'hA0, 4, -1);
    endtask

    task automatic test_tie();
        int exp_w;
        winners.delete();
        for (int t = 0; t < 4; t++) begin
            req0_command = 2'd2; req1_command = 2'd2;
            req0_address = A'($urandom); req1_address = A'($urandom);
            run_txn(1'b0, -1, -1, -1);
        end
        // after the reset preference for requester 0, ties must alternate
        for (int t = 0; t < 4; t++) begin
            exp_w = t % 2;
            nvec++;
            if (t >= winners.size() || winners[t] != exp_w) begin
                nerr++;
                $display("FAIL tie_order%0d got %0d want %0d", t,
                         (t < winners.size()) ? winners[t] : -1, exp_w);
            end
        end
        req0_command = 2'd0; req1_command = 2'd0;
    endtask

    task automatic test_read_gaps();
        req1_command = 2'd2; req1_address = A'($urandom); req0_command = 2'd0;
        run_txn(1'b1, -1, -1, -1);
    endtask

    task automatic test_abort();
        req1_command = 2'd3; req1_address = A'($urandom); req0_command = 2'd0;
        run_txn(1'b0, -1, -1, 3);
        req1_command = 2'd2; req1_address = A'($urandom);
        run_txn(1'b1, -1, -1, -1);
    endtask

    task automatic test_nop();
        for (int i = 0; i < 3; i++) begin
            req0_command = (i == 1) ? 2'd0 : 2'd1;
            req1_command = (i == 0) ? 2'd0 : 2'd1;
            run_txn(1'b0, -1, -1, -1);
        end
        req0_command = 2'd0; req1_command = 2'd0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            req0_command = 2'($urandom); req1_command = 2'($urandom);
            req0_address = A'($urandom); req1_address = A'($urandom);
            run_txn(1'($urandom), -1, -1, -1);
            req0_command = 2'd0; req1_command = 2'd0;
        end
    endtask

    initial begin
        reset = 1'b0;
        req0_command = 2'd0; req1_command = 2'd0;
        req0_address = '0; req1_address = '0;
        req0_wdata = '0; req1_wdata = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; mem_response = 1'b0;
        test_reset();
        test_read_fixed();
        test_write_fixed();
        test_tie();
        test_read_gaps();
        test_abort();
        test_nop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $fatal(1, "timeout");
    end
endmodule
